// File: rtl/mac_feeder.sv
// mac_feeder: buffers (a,b) operand pairs in a FIFO and sequences them into
// an external 8x8 multiply-accumulate unit in frames of LEN terms, then
// captures the accumulator as one dot-product result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Input side: in_valid/in_ready, where in_ready depends only on
// the FIFO count. Result side: res_valid/res_ready, where res_valid holds
// with res_data stable until the transfer. res_valid never depends on
// res_ready.
module mac_feeder #(
  parameter int LEN   = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  output logic [7:0]    mac_opa,
  output logic [7:0]    mac_opb,
  output logic          mac_clr,
  input  logic [15:0]   mac_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic [AW:0]   fifo_cnt,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   term;
  logic          push;
  logic          pop;

  assign in_ready  = (fifo_cnt < (AW+1)'(DEPTH));
  assign push      = in_valid & in_ready;
  assign dbg_state = state;

  // Next-state logic. A pair is popped on every edge that begins a FEED
  // cycle, so the registered operands show pair k during FEED cycle k.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (fifo_cnt >= (AW+1)'(LEN)) state_next = CLEAR;
      CLEAR: state_next = FEED;
      FEED:  if (term == (AW+1)'(LEN - 1)) state_next = DRAIN;
      DRAIN: state_next = HOLD;
      HOLD:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A frame only starts with LEN pairs stored, so FEED never underflows.
    pop = (state_next == FEED);
  end

  // FIFO storage; pushes offered during clr are dropped.
  always_ff @(posedge clk) begin
    if (!clr && push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Frame state, term counter, registered MAC drive and result capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      term      <= '0;
      mac_clr   <= 1'b0;
      mac_opa   <= 8'h00;
      mac_opb   <= 8'h00;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
    end else begin
      state   <= state_next;
      mac_clr <= (state_next == CLEAR);
      // Zero operands outside FEED keep the always-accumulating MAC still.
      if (pop) begin
        mac_opa <= mem[rd_ptr][15:8];
        mac_opb <= mem[rd_ptr][7:0];
      end else begin
        mac_opa <= 8'h00;
        mac_opb <= 8'h00;
      end
      if (state == CLEAR)     term <= '0;
      else if (state == FEED) term <= term + (AW+1)'(1);
      res_valid <= (state_next == HOLD);
      // The last term has been accumulated by the start of DRAIN.
      if (state == DRAIN) res_data <= mac_out;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed tests for mac_feeder against an ideal MAC model,
// with a result scoreboard checked by a separate monitor.
module tb_mac_feeder;

  localparam int LEN   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [7:0]    mac_opa;
  logic [7:0]    mac_opb;
  logic          mac_clr;
  logic [15:0]   mac_out = 16'h0000;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic [AW:0]   fifo_cnt;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  int valid_cycles = 0;
  int clr_pulses   = 0;
  int cnt_watch    = 0;
  int cnt_max      = 0;
  int cnt_step_err = 0;
  logic [AW:0] prev_cnt = '0;

  mac_feeder #(.LEN(LEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_opa   (mac_opa),
    .mac_opb   (mac_opb),
    .mac_clr   (mac_clr),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .fifo_cnt  (fifo_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and ideal MAC model
  always #5 clk = ~clk;

  always @(posedge clk)
    mac_out <= mac_clr ? 16'h0000 : mac_out + ({8'h00, mac_opa} * {8'h00, mac_opb});

  // Global watchdog
  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: result scoreboard plus activity counters
  always @(negedge clk) begin
    if (!clr) begin
      if (res_valid) valid_cycles++;
      if (mac_clr) clr_pulses++;
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL res_unexpected actual=%0h required=none", res_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (res_data !== e) begin
            failures++;
            $display("FAIL res_data actual=%0h required=%0h", res_data, e);
          end
        end
      end
      if (cnt_watch != 0) begin
        int d;
        d = int'(fifo_cnt) - int'(prev_cnt);
        if (d > 1 || d < -1) cnt_step_err++;
        if (int'(fifo_cnt) > cnt_max) cnt_max = int'(fifo_cnt);
      end
      prev_cnt = fifo_cnt;
    end
  end

  // Driver tasks (called at posedge+1)
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=%0d required=<200", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
  endtask

  logic [7:0] e_a [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
  logic [7:0] e_b [4] = '{8'd2, 8'd4, 8'd6, 8'd8};

  initial begin
    int err;
    clr = 1'b1;
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
    res_ready = 1'b1;
    // Reset with a push offered; it must be discarded
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk("rst_cnt", 32'(fifo_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_mac", {mac_opa, mac_opb, 7'd0, mac_clr}, 0);
    @(posedge clk);
    #1;

    // Test 1: basic frame, mac_clr timing, operand order, 1-cycle valid
    valid_cycles = 0;
    exp_q.push_back(16'h0064);
    for (int i = 0; i < 4; i++) push(e_a[i], e_b[i]);
    @(negedge clk);
    chk("t1_cnt4", 32'(fifo_cnt), 4);
    chk("t1_clr_early", 32'(mac_clr), 0);
    @(negedge clk);
    chk("t1_clr_pulse", 32'(mac_clr), 1);
    chk("t1_opa_clear", 32'(mac_opa), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_opa", 32'(mac_opa), 32'(e_a[i]));
      chk("t1_opb", 32'(mac_opb), 32'(e_b[i]));
      chk("t1_clr_low", 32'(mac_clr), 0);
    end
    @(negedge clk);
    chk("t1_opa_drain", 32'(mac_opa), 0);
    @(posedge clk);
    #1;
    wait_empty("t1");
    chk("t1_valid_cycles", valid_cycles, 1);

    // Test 2: back-pressure, full FIFO, refused 13th push
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0004);
    for (int i = 0; i < 12; i++) push(8'd1, 8'd1);
    wait_valid("t2_hold");
    chk("t2_state_hold", 32'(dbg_state), 4);
    chk("t2_res_data", 32'(res_data), 32'h0004);
    chk("t2_cnt_full", 32'(fifo_cnt), 8);
    chk("t2_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    err = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready || fifo_cnt != 8) err++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t2_refused", err, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    wait_valid("t2_second");
    chk("t2_cnt_after2", 32'(fifo_cnt), 4);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_empty("t2");
    chk("t2_cnt_end", 32'(fifo_cnt), 0);

    // Test 3: wrap of 16-bit sum
    exp_q.push_back(16'hF804);
    for (int i = 0; i < 4; i++) push(8'd255, 8'd255);
    wait_empty("t3");

    // Test 4: reset during the 2nd FEED cycle
    for (int i = 0; i < 4; i++) push(8'd9, 8'd9);
    err = 0;
    @(negedge clk);
    while (dbg_state != 3'd2 && err < 50) begin
      err++;
      @(negedge clk);
    end
    chk("t4_reach_feed", 32'(dbg_state), 2);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("t4_state", 32'(dbg_state), 0);
    chk("t4_cnt", 32'(fifo_cnt), 0);
    chk("t4_res_valid", 32'(res_valid), 0);
    chk("t4_opa", 32'(mac_opa), 0);
    @(posedge clk);
    #1;
    clr_pulses = 0;
    exp_q.push_back(16'h0004);
    for (int i = 0; i < 4; i++) push(8'd1, 8'd1);
    wait_empty("t4");
    chk("t4_clr_pulses", clr_pulses, 1);

    // Test 5: continuous streaming of 8 frames
    cnt_max = 0;
    cnt_step_err = 0;
    cnt_watch = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0018);
    for (int i = 0; i < 32; i++) push(8'd2, 8'd3);
    wait_empty("t5");
    cnt_watch = 0;
    chk("t5_cnt_max_le_depth", 32'(cnt_max <= DEPTH), 1);
    chk("t5_cnt_reached_full", cnt_max, DEPTH);
    chk("t5_cnt_steps", cnt_step_err, 0);
    chk("t5_cnt_end", 32'(fifo_cnt), 0);

    // Test 6: partial frame never starts
    clr_pulses = 0;
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) push(8'd4, 8'd5);
    err = 0;
    repeat (50) begin
      @(negedge clk);
      if (mac_clr || mac_opa != 0 || mac_opb != 0 || res_valid) err++;
    end
    chk("t6_quiet", err, 0);
    chk("t6_clr_pulses", clr_pulses, 0);
    chk("t6_cnt", 32'(fifo_cnt), 3);
    chk("t6_state", 32'(dbg_state), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
